tl_tag_manager: RTL and testbench

- Owns the non-posted tag pool for the transaction layer.
- Arbitrates round-robin between NUM_REQ read requesters and hands each accepted request the lowest-numbered free tag.
- Stores per-tag request metadata (requester ID, address, length, attributes) and serves the completion engine's combinational lookup.
- Returns tags to the pool on the completion engine's free strobe, and supports a drain mode for quiescing before link reset or power transitions.

---
 rtl/tl_tag_manager.sv | 179 +++++++++++++++++
 tb/tb_tl_tag_manager.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tag_manager.sv
// Non-posted tag pool: round-robin arbitration across read requesters,
// lowest-free-tag allocation, per-tag metadata store with combinational
// lookup for the completion engine, tag release and drain handling.
module tl_tag_manager #(
  parameter int TAG_W    = 8,
  parameter int NUM_TAGS = 32,
  parameter int NUM_REQ  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [16*NUM_REQ-1:0]           req_id_i,
  input  logic [32*NUM_REQ-1:0]           req_addr_i,
  input  logic [10*NUM_REQ-1:0]           req_len_i,
  input  logic [3*NUM_REQ-1:0]            req_attr_i,
  output logic [TAG_W-1:0]                alloc_tag_o,
  input  logic [TAG_W-1:0]                lookup_tag_i,
  input  logic                            lookup_valid_i,
  output logic                            lookup_ready_o,
  output logic [15:0]                     lookup_req_id_o,
  output logic [31:0]                     lookup_addr_o,
  output logic [9:0]                      lookup_len_o,
  output logic [2:0]                      lookup_attr_o,
  output logic                            lookup_hit_o,
  input  logic [TAG_W-1:0]                free_tag_i,
  input  logic                            free_valid_i,
  output logic                            free_err_o,
  input  logic                            drain_i,
  output logic                            drain_done_o,
  output logic [$clog2(NUM_TAGS+1)-1:0]   outstanding_o
);

  localparam int IDX_W  = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int RR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(NUM_TAGS+1);
  localparam int META_W = 16 + 32 + 10 + 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_TAGS-1:0] busy_q;
  logic [RR_W-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]    outstanding_q;
  logic                free_err_p1;
  logic [META_W-1:0]   meta_mem [NUM_TAGS];

  logic                run_en;
  logic                drain_done;
  logic                win_found;
  logic [RR_W-1:0]     winner;
  logic                any_free;
  logic [IDX_W-1:0]    free_slot;
  logic                grant;
  logic [NUM_REQ-1:0]  ready;
  logic [META_W-1:0]   winner_meta;
  logic                free_in_range;
  logic [IDX_W-1:0]    free_idx;
  logic                free_legal;
  logic                lookup_in_range;
  logic [IDX_W-1:0]    lookup_idx;
  logic                lookup_hit;
  logic [META_W-1:0]   lookup_data;

  // Run/drain mode: next state and the mode-dependent enables
  always_comb begin
    state_d    = state_q;
    run_en     = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_en = 1'b1;
        if (drain_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_done = (outstanding_q == '0);
        if (!drain_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Round-robin search for the first valid requester starting at rr_ptr
  always_comb begin
    logic [RR_W:0] sum;
    sum       = '0;
    win_found = 1'b0;
    winner    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
      if (sum >= (RR_W+1)'(NUM_REQ)) sum = sum - (RR_W+1)'(NUM_REQ);
      if (!win_found && req_valid_i[sum[RR_W-1:0]]) begin
        win_found = 1'b1;
        winner    = sum[RR_W-1:0];
      end
    end
  end

  // Lowest-numbered free tag from the registered busy vector
  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    for (int t = NUM_TAGS-1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        any_free  = 1'b1;
        free_slot = IDX_W'(t);
      end
    end
  end

  // Grant decode: one-hot ready and the winner's metadata
  always_comb begin
    grant       = run_en && any_free && win_found;
    ready       = '0;
    winner_meta = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == RR_W'(k)) begin
        ready[k]    = grant;
        winner_meta = {req_id_i[k*16 +: 16], req_addr_i[k*32 +: 32],
                       req_len_i[k*10 +: 10], req_attr_i[k*3 +: 3]};
      end
    end
  end

  // Free legality and completion-side lookup
  always_comb begin
    free_in_range   = {1'b0, free_tag_i} < (TAG_W+1)'(NUM_TAGS);
    free_idx        = free_tag_i[IDX_W-1:0];
    free_legal      = free_valid_i && free_in_range && busy_q[free_idx];
    lookup_in_range = {1'b0, lookup_tag_i} < (TAG_W+1)'(NUM_TAGS);
    lookup_idx      = lookup_tag_i[IDX_W-1:0];
    lookup_hit      = lookup_valid_i && lookup_in_range && busy_q[lookup_idx];
    lookup_data     = lookup_hit ? meta_mem[lookup_idx] : '0;
  end

  // Control state: mode, busy vector, arbitration pointer, counter, error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      busy_q        <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      free_err_p1   <= 1'b0;
    end else begin
      state_q     <= state_d;
      free_err_p1 <= free_valid_i && !free_legal;
      if (free_legal) busy_q[free_idx] <= 1'b0;
      if (grant) begin
        busy_q[free_slot] <= 1'b1;
        rr_ptr_q <= (winner == RR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      end
      if (grant && !free_legal)
        outstanding_q <= outstanding_q + 1'b1;
      else if (!grant && free_legal)
        outstanding_q <= outstanding_q - 1'b1;
    end
  end

  // Metadata capture for the allocated tag; storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (grant) meta_mem[free_slot] <= winner_meta;
  end

  assign req_ready_o     = ready;
  assign alloc_tag_o     = grant ? TAG_W'(free_slot) : '0;
  assign lookup_ready_o  = 1'b1;
  assign lookup_hit_o    = lookup_hit;
  assign lookup_req_id_o = lookup_data[60:45];
  assign lookup_addr_o   = lookup_data[44:13];
  assign lookup_len_o    = lookup_data[12:3];
  assign lookup_attr_o   = lookup_data[2:0];
  assign free_err_o      = free_err_p1;
  assign drain_done_o    = drain_done;
  assign outstanding_o   = outstanding_q;

endmodule

// File: tb/tb_tl_tag_manager.sv
// Scoreboard bench for tl_tag_manager: stimulus queues expected grants,
// error pulses and lookups; a negedge monitor pops and compares them.
module tb_tl_tag_manager;

  localparam int TAG_W    = 8;
  localparam int NUM_TAGS = 32;
  localparam int NUM_REQ  = 2;
  localparam int CNT_W    = $clog2(NUM_TAGS+1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_id;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [10*NUM_REQ-1:0] req_len;
  logic [3*NUM_REQ-1:0]  req_attr;
  logic [TAG_W-1:0]      alloc_tag;
  logic [TAG_W-1:0]      lookup_tag;
  logic                  lookup_valid;
  logic                  lookup_ready;
  logic [15:0]           lookup_req_id;
  logic [31:0]           lookup_addr;
  logic [9:0]            lookup_len;
  logic [2:0]            lookup_attr;
  logic                  lookup_hit;
  logic [TAG_W-1:0]      free_tag;
  logic                  free_valid;
  logic                  free_err;
  logic                  drain;
  logic                  drain_done;
  logic [CNT_W-1:0]      outstanding;

  always #5 clk = ~clk;

  tl_tag_manager #(.TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_id_i(req_id), .req_addr_i(req_addr), .req_len_i(req_len), .req_attr_i(req_attr),
    .alloc_tag_o(alloc_tag),
    .lookup_tag_i(lookup_tag), .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_req_id_o(lookup_req_id), .lookup_addr_o(lookup_addr),
    .lookup_len_o(lookup_len), .lookup_attr_o(lookup_attr), .lookup_hit_o(lookup_hit),
    .free_tag_i(free_tag), .free_valid_i(free_valid), .free_err_o(free_err),
    .drain_i(drain), .drain_done_o(drain_done), .outstanding_o(outstanding)
  );

  typedef struct packed {
    logic [1:0]  rdy;
    logic [7:0]  tag;
    logic [31:0] cyc;
  } grant_t;

  typedef struct packed {
    logic        hit;
    logic        chk_data;
    logic [15:0] id;
    logic [31:0] addr;
    logic [9:0]  len;
    logic [2:0]  attr;
  } look_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc_cnt = '0;
  grant_t      gq[$];
  logic [31:0] eq[$];
  look_t       lq[$];
  grant_t      g_pop;
  look_t       l_pop;
  logic [31:0] e_pop;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic v, input logic [15:0] id,
                         input logic [31:0] a, input logic [9:0] l, input logic [2:0] at);
    req_valid[r]          = v;
    req_id[r*16 +: 16]    = id;
    req_addr[r*32 +: 32]  = a;
    req_len[r*10 +: 10]   = l;
    req_attr[r*3 +: 3]    = at;
  endtask

  task automatic exp_grant(input logic [1:0] rdy, input logic [7:0] tag);
    gq.push_back('{rdy: rdy, tag: tag, cyc: cyc_cnt});
  endtask

  task automatic do_free(input logic [7:0] tag, input logic exp_err);
    free_tag   = tag;
    free_valid = 1'b1;
    if (exp_err) eq.push_back(cyc_cnt + 1);
  endtask

  task automatic look(input logic [7:0] tag, input logic hit, input logic chk_data,
                      input logic [15:0] id, input logic [31:0] a, input logic [9:0] l,
                      input logic [2:0] at);
    lookup_tag   = tag;
    lookup_valid = 1'b1;
    lq.push_back('{hit: hit, chk_data: chk_data, id: id, addr: a, len: l, attr: at});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst) begin
      if (|req_ready) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected: ready=%b tag=%0d, none expected (cycle %0d)", req_ready, alloc_tag, cyc_cnt);
        end else begin
          g_pop = gq.pop_front();
          chk("grant_ready", 64'(req_ready), 64'(g_pop.rdy));
          chk("grant_tag", 64'(alloc_tag), 64'(g_pop.tag));
          chk("grant_cycle", 64'(cyc_cnt), 64'(g_pop.cyc));
        end
      end else if (gq.size() > 0 && gq[0].cyc <= cyc_cnt) begin
        g_pop = gq.pop_front();
        checks++; errors++;
        $display("FAIL grant_missing: ready=0 expected ready=%b tag=%0d (cycle %0d)", g_pop.rdy, g_pop.tag, cyc_cnt);
      end

      if (free_err) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL free_err_unexpected: free_err=1 expected 0 (cycle %0d)", cyc_cnt);
        end else begin
          e_pop = eq.pop_front();
          chk("free_err_cycle", 64'(cyc_cnt), 64'(e_pop));
        end
      end else if (eq.size() > 0 && eq[0] <= cyc_cnt) begin
        e_pop = eq.pop_front();
        checks++; errors++;
        $display("FAIL free_err_missing: free_err=0 expected 1 (cycle %0d)", cyc_cnt);
      end

      if (lookup_valid) begin
        if (lq.size() == 0) begin
          checks++; errors++;
          $display("FAIL lookup_unexpected: no expectation queued (cycle %0d)", cyc_cnt);
        end else begin
          l_pop = lq.pop_front();
          chk("lookup_hit", 64'(lookup_hit), 64'(l_pop.hit));
          if (l_pop.chk_data) begin
            chk("lookup_id", 64'(lookup_req_id), 64'(l_pop.id));
            chk("lookup_addr", 64'(lookup_addr), 64'(l_pop.addr));
            chk("lookup_len", 64'(lookup_len), 64'(l_pop.len));
            chk("lookup_attr", 64'(lookup_attr), 64'(l_pop.attr));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_id = '0; req_addr = '0; req_len = '0; req_attr = '0;
    lookup_tag = '0; lookup_valid = 1'b0;
    free_tag = '0; free_valid = 1'b0;
    drain = 1'b0;

    // Reset values
    repeat (3) cyc();
    settle();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_free_err", 64'(free_err), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_lookup_ready", 64'(lookup_ready), 64'd1);
    chk("rst_lookup_hit", 64'(lookup_hit), 64'd0);
    cyc(); rst = 1'b0;

    // Single grant then lookup
    cyc(); set_req(0, 1'b1, 16'h00A0, 32'h0000_1000, 10'd4, 3'b010); exp_grant(2'b01, 8'd0);
    cyc(); set_req(0, 1'b0, 16'h0, 32'h0, 10'd0, 3'd0);
    look(8'd0, 1'b1, 1'b1, 16'h00A0, 32'h0000_1000, 10'd4, 3'b010);
    settle(); chk("single_outstanding", 64'(outstanding), 64'd1);
    cyc(); lookup_valid = 1'b0;

    // Reset mid-operation: the previously busy tag is now idle, so freeing it errors
    rst = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); do_free(8'd0, 1'b1);
    cyc(); free_valid = 1'b0;
    settle(); chk("rstmid_outstanding", 64'(outstanding), 64'd0);

    // Round-robin fairness, then fill the pool from requester 0
    for (int t = 0; t < 4; t++) begin
      cyc();
      if (t == 0) begin
        set_req(0, 1'b1, 16'h0011, 32'h0000_2000, 10'd8, 3'b001);
        set_req(1, 1'b1, 16'h0022, 32'h0000_3000, 10'd16, 3'b100);
      end
      exp_grant((t % 2 == 0) ? 2'b01 : 2'b10, 8'(t));
    end
    for (int t = 4; t < NUM_TAGS; t++) begin
      cyc();
      if (t == 4) set_req(1, 1'b0, 16'h0, 32'h0, 10'd0, 3'd0);
      exp_grant(2'b01, 8'(t));
    end

    // Full pool
    cyc(); look(8'd3, 1'b1, 1'b1, 16'h0022, 32'h0000_3000, 10'd16, 3'b100);
    settle();
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_outstanding", 64'(outstanding), 64'd32);
    cyc(); lookup_valid = 1'b0; do_free(8'd5, 1'b0);
    settle(); chk("full_ready_on_free", 64'(req_ready), 64'd0);
    cyc(); free_valid = 1'b0; exp_grant(2'b01, 8'd5);
    settle(); chk("full_outstanding_freed", 64'(outstanding), 64'd31);
    cyc(); set_req(0, 1'b1, 16'h0055, 32'h0000_5000, 10'd1, 3'b111);
    req_valid[0] = 1'b0;
    look(8'd5, 1'b1, 1'b1, 16'h0011, 32'h0000_2000, 10'd8, 3'b001);
    settle(); chk("full_outstanding_refill", 64'(outstanding), 64'd32);
    cyc(); look(8'd40, 1'b0, 1'b1, 16'h0, 32'h0, 10'd0, 3'd0);

    // Same-cycle free and grant
    cyc(); lookup_valid = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); set_req(0, 1'b1, 16'h0033, 32'h0000_4000, 10'd2, 3'b000); exp_grant(2'b01, 8'd0);
    cyc(); exp_grant(2'b01, 8'd1);
    cyc(); exp_grant(2'b01, 8'd2);
    cyc(); do_free(8'd1, 1'b0); exp_grant(2'b01, 8'd3);
    cyc(); free_valid = 1'b0; exp_grant(2'b01, 8'd1);
    settle(); chk("sc_outstanding", 64'(outstanding), 64'd3);
    cyc(); set_req(0, 1'b0, 16'h0, 32'h0, 10'd0, 3'd0);
    settle(); chk("sc_outstanding_after", 64'(outstanding), 64'd4);

    // Illegal frees: idle tag and out-of-range tag
    cyc(); do_free(8'd7, 1'b1);
    cyc(); do_free(8'd40, 1'b1);
    cyc(); free_valid = 1'b0;
    settle(); chk("ill_outstanding", 64'(outstanding), 64'd4);
    cyc();
    settle(); chk("ill_err_clear", 64'(free_err), 64'd0);

    // Drain with three tags outstanding
    cyc(); do_free(8'd3, 1'b0);
    cyc(); free_valid = 1'b0; drain = 1'b1;
    settle();
    chk("drain_outstanding", 64'(outstanding), 64'd3);
    chk("drain_done_run", 64'(drain_done), 64'd0);
    cyc();
    set_req(0, 1'b1, 16'h0066, 32'h0000_6000, 10'd3, 3'b011);
    set_req(1, 1'b1, 16'h0077, 32'h0000_7000, 10'd5, 3'b101);
    settle();
    chk("drain_no_grant", 64'(req_ready), 64'd0);
    chk("drain_done_busy3", 64'(drain_done), 64'd0);
    cyc(); do_free(8'd0, 1'b0);
    settle(); chk("drain_done_busy3b", 64'(drain_done), 64'd0);
    cyc(); do_free(8'd1, 1'b0);
    settle(); chk("drain_outstanding2", 64'(outstanding), 64'd2);
    cyc(); do_free(8'd2, 1'b0);
    settle();
    chk("drain_outstanding1", 64'(outstanding), 64'd1);
    chk("drain_done_busy1", 64'(drain_done), 64'd0);
    cyc(); free_valid = 1'b0;
    settle();
    chk("drain_outstanding0", 64'(outstanding), 64'd0);
    chk("drain_done_set", 64'(drain_done), 64'd1);
    chk("drain_ready_idle", 64'(req_ready), 64'd0);
    cyc(); drain = 1'b0;
    settle(); chk("drain_exit_ready", 64'(req_ready), 64'd0);
    cyc(); exp_grant(2'b10, 8'd0);
    cyc(); exp_grant(2'b01, 8'd1);
    cyc();
    set_req(0, 1'b0, 16'h0, 32'h0, 10'd0, 3'd0);
    set_req(1, 1'b0, 16'h0, 32'h0, 10'd0, 3'd0);
    settle();
    chk("resume_outstanding", 64'(outstanding), 64'd2);
    chk("resume_drain_done", 64'(drain_done), 64'd0);

    // Everything expected must have been observed
    repeat (2) cyc();
    settle();
    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("err_queue_empty", 64'(eq.size()), 64'd0);
    chk("lookup_queue_empty", 64'(lq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
